// File: rtl/load_align_unit.sv
// Load alignment: selects and extends the addressed byte/halfword from a memory word.
// Define LOAD_MISALIGN_CHECK_EN to add misalignment detection with sticky error status.
module load_align_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_data,
  input  logic [1:0]  addr_rem,
  input  logic [31:0] alu_result,
  input  logic [2:0]  info_load,
  input  logic        err_clr,
  output logic [31:0] data,
  output logic        misaligned,
  output logic        err_sticky,
  output logic [31:0] err_addr
);

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LB   = 3'b001,
    LD_LH   = 3'b010,
    LD_LW   = 3'b011,
    LD_LBU  = 3'b100,
    LD_LHU  = 3'b101
  } load_kind_e;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    case (addr_rem)
      2'd0: begin byte_sel = addr_data[7:0];   half_sel = addr_data[15:0];  end
      2'd1: begin byte_sel = addr_data[15:8];  half_sel = addr_data[23:8];  end
      2'd2: begin byte_sel = addr_data[23:16]; half_sel = addr_data[31:16]; end
      default: begin byte_sel = addr_data[31:24]; half_sel = 16'h0000; end
    endcase
  end

  // A halfword straddling the word boundary cannot be assembled from one word, so it reads as 0.
  always_comb begin
    data = 32'h0000_0000;
    case (info_load)
      LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: data = {24'h000000, byte_sel};
      LD_LH:  data = (addr_rem == 2'd3) ? 32'h0 : {{16{half_sel[15]}}, half_sel};
      LD_LHU: data = (addr_rem == 2'd3) ? 32'h0 : {16'h0000, half_sel};
      LD_LW:  data = addr_data;
      default: data = 32'h0000_0000;
    endcase
  end

`ifdef LOAD_MISALIGN_CHECK_EN
  logic        misaligned_w;
  logic        sticky_q;
  logic [31:0] addr_q;

  always_comb begin
    misaligned_w = 1'b0;
    case (info_load)
      LD_LH, LD_LHU: misaligned_w = (addr_rem == 2'd3);
      LD_LW:         misaligned_w = (addr_rem != 2'd0);
      default:       misaligned_w = 1'b0;
    endcase
  end

  // Only the first misaligned address is captured; clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      addr_q   <= 32'h0000_0000;
    end else if (err_clr) begin
      sticky_q <= 1'b0;
    end else if (misaligned_w && !sticky_q) begin
      sticky_q <= 1'b1;
      addr_q   <= alu_result;
    end
  end

  assign misaligned = misaligned_w;
  assign err_sticky = sticky_q;
  assign err_addr   = addr_q;
`else
  logic unused_status_inputs;

  assign unused_status_inputs = ^{clk, rst_n, alu_result, err_clr};
  assign misaligned = 1'b0;
  assign err_sticky = 1'b0;
  assign err_addr   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: directed vectors plus random loads
// compared against an arithmetic reference model of alignment and sticky status.
module tb_load_align_unit;

`ifdef LOAD_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_data;
  logic [1:0]  addr_rem;
  logic [31:0] alu_result;
  logic [2:0]  info_load;
  logic        err_clr;
  logic [31:0] data;
  logic        misaligned;
  logic        err_sticky;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;
  logic        exp_sticky;
  logic [31:0] exp_addr;

  always #5 clk = ~clk;

  load_align_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_data  (addr_data),
    .addr_rem   (addr_rem),
    .alu_result (alu_result),
    .info_load  (info_load),
    .err_clr    (err_clr),
    .data       (data),
    .misaligned (misaligned),
    .err_sticky (err_sticky),
    .err_addr   (err_addr)
  );

  // Reference: shift the word right by the byte offset, mask, then extend arithmetically.
  function automatic logic [31:0] ref_data(input logic [31:0] w, input int rem, input int kind);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * rem)) % 32'd256;
    h = (w >> (8 * rem)) % 32'd65536;
    case (kind)
      1: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      2: return (rem == 3) ? 32'd0 : ((h >= 32'd32768) ? h + 32'hFFFF_0000 : h);
      5: return (rem == 3) ? 32'd0 : h;
      3: return w;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_mis(input int rem, input int kind);
    if (!CHECK_EN) return 1'b0;
    if ((kind == 2 || kind == 5) && rem == 3) return 1'b1;
    if (kind == 3 && rem != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one load away from the edge, checks the combinational result, then the status after the edge.
  task automatic applyStimulus(input logic [31:0] ad, input logic [1:0] rem, input logic [31:0] alu,
                               input logic [2:0] kind, input logic clr, input string tag);
    logic [31:0] e_data;
    logic        e_mis;
    addr_data  = ad;
    addr_rem   = rem;
    alu_result = alu;
    info_load  = kind;
    err_clr    = clr;
    e_data = ref_data(ad, int'(rem), int'(kind));
    e_mis  = ref_mis(int'(rem), int'(kind));
    #1;
    checkOutput({tag, ".data"}, data, e_data);
    checkOutput({tag, ".mis"}, {31'd0, misaligned}, {31'd0, e_mis});
    @(posedge clk);
    if (clr) exp_sticky = 1'b0;
    else if (e_mis && !exp_sticky) begin
      exp_sticky = 1'b1;
      exp_addr   = alu;
    end
    #1;
    checkOutput({tag, ".sticky"}, {31'd0, err_sticky}, {31'd0, exp_sticky});
    checkOutput({tag, ".eaddr"}, err_addr, exp_addr);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r_alu;
    rst_n      = 1'b0;
    addr_data  = 32'h0;
    addr_rem   = 2'd0;
    alu_result = 32'h0;
    info_load  = 3'b000;
    err_clr    = 1'b0;
    exp_sticky = 1'b0;
    exp_addr   = 32'h0;
    #12;
    checkOutput("reset.sticky", {31'd0, err_sticky}, 32'd0);
    checkOutput("reset.eaddr", err_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(32'h80F17F22, 2'd0, 32'h100, 3'b001, 1'b0, "lb0");
    applyStimulus(32'h80F17F22, 2'd1, 32'h101, 3'b001, 1'b0, "lb1");
    applyStimulus(32'h80F17F22, 2'd2, 32'h102, 3'b001, 1'b0, "lb2");
    applyStimulus(32'h80F17F22, 2'd3, 32'h103, 3'b001, 1'b0, "lb3");
    applyStimulus(32'h80F17F22, 2'd3, 32'h103, 3'b100, 1'b0, "lbu3");
    checkOutput("lbu3.const", data, 32'h00000080);
    applyStimulus(32'h8001F234, 2'd0, 32'h200, 3'b010, 1'b0, "lh0");
    applyStimulus(32'h8001F234, 2'd1, 32'h201, 3'b010, 1'b0, "lh1");
    applyStimulus(32'h8001F234, 2'd2, 32'h202, 3'b010, 1'b0, "lh2");
    checkOutput("lh2.const", data, 32'hFFFF8001);
    applyStimulus(32'h8001F234, 2'd2, 32'h202, 3'b101, 1'b0, "lhu2");
    applyStimulus(32'hDEADBEEF, 2'd0, 32'h300, 3'b011, 1'b0, "lw0");
    applyStimulus(32'hDEADBEEF, 2'd2, 32'h302, 3'b011, 1'b1, "lw2");

    applyStimulus(32'h12345678, 2'd3, 32'h00001003, 3'b010, 1'b0, "mis1");
    applyStimulus(32'h12345678, 2'd1, 32'h00002001, 3'b011, 1'b0, "mis2");
    applyStimulus(32'h12345678, 2'd3, 32'h00004003, 3'b101, 1'b1, "clrset");
    applyStimulus(32'h12345678, 2'd2, 32'h00003002, 3'b011, 1'b0, "mis3");

    #2 rst_n = 1'b0;
    exp_sticky = 1'b0;
    exp_addr   = 32'h0;
    #1;
    checkOutput("midrst.sticky", {31'd0, err_sticky}, 32'd0);
    checkOutput("midrst.eaddr", err_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(32'hFFFFFFFF, 2'd3, 32'h00005003, 3'b110, 1'b0, "rsv6");
    applyStimulus(32'hA5A5A5A5, 2'd1, 32'h00005005, 3'b111, 1'b0, "rsv7");

    for (int i = 0; i < 60; i++) begin
      r_alu = $urandom;
      applyStimulus($urandom, r_alu[1:0], r_alu, 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
